// File: rtl/mem_loader_if.sv
// mem_loader_if: groups the host stream, memory bus and status signals of mem_loader.
//   Host input stream : in_valid, in_ready, in_data
//   Host dump stream  : out_valid, out_ready, out_data, out_last
//   Memory bus        : addr_ext, Data_in_ins, Data_in_dram, iram_write_ext,
//                       dram_write_ext, read_en_ext, dram_in
//   Mode / status     : start, start_2, start_3, start_4, busy, done
// master = the loader, slave = host plus memories.
interface mem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [ADDR_W-1:0] addr_ext;
  logic [DATA_W-1:0] Data_in_ins;
  logic [DATA_W-1:0] Data_in_dram;
  logic              iram_write_ext;
  logic              dram_write_ext;
  logic              read_en_ext;
  logic [DATA_W-1:0] dram_in;
  logic              start;
  logic              start_2;
  logic              start_3;
  logic              start_4;
  logic              busy;
  logic              done;

  modport master (
    input  in_valid, in_data, out_ready, dram_in,
    output in_ready, out_valid, out_data, out_last, addr_ext, Data_in_ins,
           Data_in_dram, iram_write_ext, dram_write_ext, read_en_ext,
           start, start_2, start_3, start_4, busy, done
  );

  modport slave (
    output in_valid, in_data, out_ready, dram_in,
    input  in_ready, out_valid, out_data, out_last, addr_ext, Data_in_ins,
           Data_in_dram, iram_write_ext, dram_write_ext, read_en_ext,
           start, start_2, start_3, start_4, busy, done
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: takes a 4-word header {iram_cnt, dram_cnt, final_start, final_end}
// from the host stream, writes iram_cnt words to IRAM and dram_cnt words to DRAM
// (addresses from 1), runs the processor for RUN_CYCLES clocks, then streams DRAM
// words final_start..final_end-1 back to the host.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : mem_loader_if master modport (host streams, memory bus, mode bits)
module mem_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int RUN_CYCLES = 120000,
  parameter int RD_LAT     = 2
) (
  input logic         clock,
  input logic         reset_n,
  mem_loader_if.master bus
);

  localparam int RUN_W = $clog2(RUN_CYCLES + 1);

  // Sub-phase inside a state. PH_GAP is an entry cycle with every mode bit low,
  // which keeps consecutive mode bits separated by an idle cycle.
  localparam logic [1:0] PH_ACC  = 2'd0;
  localparam logic [1:0] PH_STB  = 2'd1;
  localparam logic [1:0] PH_HOLD = 2'd2;
  localparam logic [1:0] PH_GAP  = 2'd3;

  typedef enum logic [2:0] {IDLE, HDR, LD_I, LD_D, RUN, DMP_RD, DMP_OUT, FIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] icnt_q, icnt_d;
  logic [ADDR_W-1:0] dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] fst_q, fst_d;
  logic [ADDR_W-1:0] fend_q, fend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] dins_q, dins_d;
  logic [DATA_W-1:0] ddram_q, ddram_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  logic [ADDR_W-1:0] word_a;
  logic              ld_i;
  logic [ADDR_W-1:0] ld_lim;
  logic              is_last;

  assign word_a  = bus.in_data[ADDR_W-1:0];
  assign ld_i    = (state_q == LD_I);
  assign ld_lim  = ld_i ? icnt_q : dcnt_q;
  assign is_last = (addr_q == fend_q - ADDR_W'(1));

  assign bus.addr_ext     = addr_q;
  assign bus.Data_in_ins  = dins_q;
  assign bus.Data_in_dram = ddram_q;
  assign bus.out_data     = odata_q;
  assign bus.busy         = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ph_q    <= PH_ACC;
      cnt_q   <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      fst_q   <= '0;
      fend_q  <= '0;
      addr_q  <= '0;
      run_q   <= '0;
      dins_q  <= '0;
      ddram_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      fst_q   <= fst_d;
      fend_q  <= fend_d;
      addr_q  <= addr_d;
      run_q   <= run_d;
      dins_q  <= dins_d;
      ddram_q <= ddram_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    fst_d   = fst_q;
    fend_d  = fend_q;
    addr_d  = addr_q;
    run_d   = run_q;
    dins_d  = dins_q;
    ddram_d = ddram_q;
    odata_d = odata_q;

    bus.in_ready       = 1'b0;
    bus.iram_write_ext = 1'b0;
    bus.dram_write_ext = 1'b0;
    bus.read_en_ext    = 1'b0;
    bus.start          = 1'b0;
    bus.start_2        = 1'b0;
    bus.start_3        = 1'b0;
    bus.start_4        = 1'b0;
    bus.out_valid      = 1'b0;
    bus.out_last       = 1'b0;
    bus.done           = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          icnt_d  = word_a;
          cnt_d   = '0;
          state_d = HDR;
        end
      end

      // cnt_q indexes the remaining header words: dram_cnt, final_start, final_end
      HDR: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(0)) begin
            dcnt_d = word_a;
          end else if (cnt_q == ADDR_W'(1)) begin
            fst_d = word_a;
          end else begin
            fend_d  = word_a;
            cnt_d   = '0;
            ph_d    = PH_GAP;
            state_d = (icnt_q != '0) ? LD_I : ((dcnt_q != '0) ? LD_D : RUN);
          end
        end
      end

      // Accept -> strobe -> hold, addresses 1..count; cnt_q counts accepted words
      LD_I, LD_D: begin
        if (ph_q != PH_GAP) begin
          bus.start_2 = ld_i;
          bus.start_3 = !ld_i;
        end
        case (ph_q)
          PH_GAP: ph_d = PH_ACC;
          PH_ACC: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
              cnt_d  = cnt_q + ADDR_W'(1);
              addr_d = cnt_q + ADDR_W'(1);
              if (ld_i) dins_d = bus.in_data;
              else      ddram_d = bus.in_data;
              ph_d = PH_STB;
            end
          end
          PH_STB: begin
            bus.iram_write_ext = ld_i;
            bus.dram_write_ext = !ld_i;
            ph_d = PH_HOLD;
          end
          default: begin
            if (cnt_q == ld_lim) begin
              cnt_d   = '0;
              ph_d    = PH_GAP;
              state_d = (ld_i && dcnt_q != '0) ? LD_D : RUN;
            end else begin
              ph_d = PH_ACC;
            end
          end
        endcase
      end

      RUN: begin
        if (ph_q == PH_GAP) begin
          ph_d  = PH_ACC;
          run_d = '0;
        end else begin
          bus.start = 1'b1;
          run_d     = run_q + RUN_W'(1);
          if (run_q == RUN_W'(RUN_CYCLES - 1)) begin
            run_d  = '0;
            cnt_d  = '0;
            addr_d = fst_q;
            ph_d   = PH_GAP;
            state_d = (fend_q <= fst_q) ? FIN : DMP_RD;
          end
        end
      end

      // read_en_ext stays high until dram_in is sampled RD_LAT cycles after it rose
      DMP_RD: begin
        if (ph_q == PH_GAP) begin
          ph_d = PH_ACC;
        end else begin
          bus.start_4     = 1'b1;
          bus.read_en_ext = 1'b1;
          cnt_d           = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(RD_LAT)) begin
            odata_d = bus.dram_in;
            cnt_d   = '0;
            state_d = DMP_OUT;
          end
        end
      end

      DMP_OUT: begin
        bus.start_4   = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = is_last;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            ph_d    = PH_ACC;
            state_d = DMP_RD;
          end
        end
      end

      FIN: begin
        bus.done = 1'b1;
        ph_d     = PH_ACC;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int RUN_CYCLES = 50;
  localparam int RD_LAT     = 2;

  typedef struct packed {
    logic              dram;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_CYCLES(RUN_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DRAM model: a read issued in cycle t shows addr+100 on dram_in in cycle t+RD_LAT;
  // any other cycle returns a poison value.
  logic [RD_LAT-1:0] rq_v = '0;
  logic [ADDR_W-1:0] rq_a [RD_LAT];
  always @(posedge clock) begin
    rq_v[0] <= bus.read_en_ext;
    rq_a[0] <= bus.addr_ext;
    for (int k = 1; k < RD_LAT; k++) begin
      rq_v[k] <= rq_v[k-1];
      rq_a[k] <= rq_a[k-1];
    end
  end
  assign bus.dram_in = rq_v[RD_LAT-1] ? (DATA_W'(rq_a[RD_LAT-1]) + 16'd100) : 16'hDEAD;

  // Host dump-side ready driver: optional random back-pressure and one-shot 10-cycle stall
  bit rnd_bp      = 1'b0;
  int stall_req   = 0;
  int stall_done  = 0;
  int stall_left  = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if (stall_req != stall_done && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left    = 9;
        stall_done++;
      end else begin
        bus.out_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: records writes, dump transfers, run lengths, done pulses and rule violations
  wr_t               wr_obs[$];
  logic [DATA_W:0]   dmp_obs[$];
  int                start_lens[$];
  int                done_cnt = 0, viol_cnt = 0, acc_cnt = 0, run_len = 0;
  logic              p_iw = 0, p_dw = 0, p_ov = 0, p_or = 0;
  logic [3:0]        p_mode = '0;
  logic [ADDR_W-1:0] p_a = '0;
  logic [DATA_W-1:0] p_di = '0, p_dd = '0, p_od = '0;

  always @(negedge clock) begin
    int v;
    logic [3:0] mode;
    v    = 0;
    mode = {bus.start, bus.start_2, bus.start_3, bus.start_4};
    if ($countones(mode) > 1) v++;
    if (p_mode != 0 && mode != 0 && p_mode != mode) v++;
    if (bus.iram_write_ext && !bus.start_2) v++;
    if (bus.dram_write_ext && !bus.start_3) v++;
    if (bus.read_en_ext && !bus.start_4) v++;
    if ((bus.iram_write_ext || bus.dram_write_ext) && bus.read_en_ext) v++;
    if ((bus.iram_write_ext && p_iw) || (bus.dram_write_ext && p_dw)) v++;
    if (p_iw && (bus.addr_ext != p_a || bus.Data_in_ins != p_di)) v++;
    if (p_dw && (bus.addr_ext != p_a || bus.Data_in_dram != p_dd)) v++;
    if (p_ov && !p_or && (!bus.out_valid || bus.out_data != p_od)) v++;
    viol_cnt <= viol_cnt + v;
    if (bus.iram_write_ext) wr_obs.push_back({1'b0, bus.addr_ext, bus.Data_in_ins});
    if (bus.dram_write_ext) wr_obs.push_back({1'b1, bus.addr_ext, bus.Data_in_dram});
    if (bus.out_valid && bus.out_ready) dmp_obs.push_back({bus.out_last, bus.out_data});
    if (bus.start) run_len <= run_len + 1;
    else if (run_len != 0) begin
      start_lens.push_back(run_len);
      run_len <= 0;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    p_iw   <= bus.iram_write_ext;
    p_dw   <= bus.dram_write_ext;
    p_ov   <= bus.out_valid;
    p_or   <= bus.out_ready;
    p_mode <= mode;
    p_a    <= bus.addr_ext;
    p_di   <= bus.Data_in_ins;
    p_dd   <= bus.Data_in_dram;
    p_od   <= bus.out_data;
  end

  // Drive one host word (caller sits just after a rising edge); waits for acceptance
  task automatic send_word(input logic [DATA_W-1:0] w);
    bit acc;
    int t;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'($urandom);
    check_eq("word_accepted", 32'(acc), 32'd1);
  endtask

  // Header word: the field in the low ADDR_W bits, random junk above
  function automatic logic [DATA_W-1:0] hdr_word(input int v);
    logic [DATA_W-1:0] hi;
    hi = DATA_W'($urandom) & ~DATA_W'((1 << ADDR_W) - 1);
    return hi | DATA_W'(v);
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_ctl"}, 32'({bus.busy, bus.done, bus.start, bus.start_2, bus.start_3,
                                 bus.start_4, bus.iram_write_ext, bus.dram_write_ext,
                                 bus.read_en_ext, bus.out_valid, bus.out_last}), 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.addr_ext), 32'd0);
    check_eq({tag, "_dins"}, 32'(bus.Data_in_ins), 32'd0);
    check_eq({tag, "_ddram"}, 32'(bus.Data_in_dram), 32'd0);
    check_eq({tag, "_odata"}, 32'(bus.out_data), 32'd0);
  endtask

  // Full sequence with scoreboard against the expected write list, run and dump
  task automatic run_seq(input int ic, input int dc, input int fs, input int fe,
                         input bit bp, input bit stall, input bit fixed_vals);
    wr_t exp_wr[$];
    logic [DATA_W-1:0] w;
    int wb, db, sb, dn, ab, vb, ndump;
    bit seen;
    wb = wr_obs.size(); db = dmp_obs.size(); sb = start_lens.size();
    dn = done_cnt; ab = acc_cnt; vb = viol_cnt;
    rnd_bp = bp;
    if (stall) stall_req++;
    send_word(hdr_word(ic));
    send_word(hdr_word(dc));
    send_word(hdr_word(fs));
    send_word(hdr_word(fe));
    for (int i = 0; i < ic; i++) begin
      w = fixed_vals ? DATA_W'(11 * (i + 1)) : DATA_W'($urandom);
      exp_wr.push_back({1'b0, ADDR_W'(i + 1), w});
      send_word(w);
    end
    for (int i = 0; i < dc; i++) begin
      w = fixed_vals ? DATA_W'(11 * (ic + i + 1)) : DATA_W'($urandom);
      exp_wr.push_back({1'b1, ADDR_W'(i + 1), w});
      send_word(w);
    end
    // Host keeps offering words during the run; none may be taken
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clock);
      seen = bus.start;
    end
    check_eq("start_seen", 32'(seen), 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b1;
    repeat (10) begin
      bus.in_data = DATA_W'($urandom);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge clock);
      seen = bus.done;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clock);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("done_pulses", 32'(done_cnt - dn), 32'd1);
    check_eq("violations", 32'(viol_cnt - vb), 32'd0);
    check_eq("acc_words", 32'(acc_cnt - ab), 32'(4 + ic + dc));
    check_eq("wr_count", 32'(wr_obs.size() - wb), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && wb + i < wr_obs.size(); i++)
      check_eq("wr_entry", 32'(wr_obs[wb + i]), 32'(exp_wr[i]));
    check_eq("run_count", 32'(start_lens.size() - sb), 32'd1);
    if (start_lens.size() > sb) check_eq("run_len", 32'(start_lens[sb]), 32'(RUN_CYCLES));
    ndump = (fe > fs) ? fe - fs : 0;
    check_eq("dump_count", 32'(dmp_obs.size() - db), 32'(ndump));
    for (int i = 0; i < ndump && db + i < dmp_obs.size(); i++)
      check_eq("dump_word", 32'(dmp_obs[db + i]),
               ((fs + i == fe - 1) ? 32'h10000 : 32'h0) | 32'((fs + i + 100) & 16'hFFFF));
    rnd_bp = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, fe;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset_n      = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("por");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Directed load/run/dump: {3,2,5,7} with 11,22,33 / 44,55
    run_seq(3, 2, 5, 7, 1'b0, 1'b0, 1'b1);
    // Back-pressure with a 10-cycle stall plus random ready
    run_seq(2, 3, 10, 16, 1'b1, 1'b1, 1'b0);
    // Empty counts and empty dump
    run_seq(0, 0, 4, 4, 1'b0, 1'b0, 1'b0);
    // final_end below final_start skips the dump
    run_seq(1, 0, 9, 3, 1'b0, 1'b0, 1'b0);
    // Dump near the top of the address space
    run_seq(0, 1, 505, 511, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of LD_D after one of two data words
    send_word(hdr_word(1));
    send_word(hdr_word(2));
    send_word(hdr_word(5));
    send_word(hdr_word(7));
    send_word(16'h1234);
    send_word(16'h5678);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check_eq("pre_rst_mode", 32'(bus.start_3), 32'd1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_vals("mid_rst");
    @(posedge clock);
    #1;
    run_seq(2, 2, 1, 3, 1'b0, 1'b0, 1'b0);

    // Randomized sequences
    for (int r = 0; r < 5; r++) begin
      fs = $urandom_range(0, 30);
      fe = fs + int'($urandom_range(0, 8)) - 2;
      if (fe < 0) fe = 0;
      run_seq($urandom_range(0, 5), $urandom_range(0, 5), fs, fe, 1'b1, r[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: ADDR_W, default 9, IRAM/DRAM address width.
REQ-002 Parameter: DATA_W, default 16, memory word width.
REQ-003 Parameter: RUN_CYCLES, default 120000, clocks that start stays high for a program run.
REQ-004 Parameter: RD_LAT, default 2, clocks from read_en_ext rising to valid dram_in.
REQ-005 Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_W  host word.
- out_valid  out  1  dump word valid.
- out_ready  in  1  host accepts the dump word.
- out_data  out  DATA_W  dumped DRAM word.
- out_last  out  1  final dump word.
- addr_ext  out  ADDR_W  external IRAM/DRAM address.
- Data_in_ins  out  DATA_W  IRAM write data.
- Data_in_dram  out  DATA_W  DRAM write data.
- iram_write_ext  out  1  IRAM write strobe.
- dram_write_ext  out  1  DRAM write strobe.
- read_en_ext  out  1  DRAM external read enable.
- dram_in  in  DATA_W  DRAM read data.
- start  out  1  processor run enable.
- start_2  out  1  IRAM external-access mode.
- start_3  out  1  DRAM external-access mode.
- start_4  out  1  DRAM external-readback mode.
- busy  out  1  state other than IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.

Function
REQ-006 States: IDLE, HDR, LD_I, LD_D, RUN, DMP_RD, DMP_OUT, FIN.
REQ-007 IDLE: in_ready=1. An accepted word is header word 0 (iram_cnt) and moves the FSM to HDR.
REQ-008 HDR: accepts three more words in order: dram_cnt, final_start, final_end. Only the low ADDR_W bits of each header word are used.
REQ-009 Handshake: a word transfers when in_valid && in_ready. in_ready is low in every state that is not consuming a word.
REQ-010 In LD_I start_2=1, and in LD_D start_3=1. Within each of LD_I and LD_D, addresses start at 1 and increment by 1 per accepted word.
REQ-011 Per-word write sequence (3 cycles):
- cycle 0: accept the word; latch addr_ext and Data_in_ins (LD_I) or Data_in_dram (LD_D).
- cycle 1: the matching write strobe is 1.
- cycle 2: strobe returns to 0 with addr and data held.
- in_ready is 0 during cycles 1-2.
REQ-012 A count of 0 skips its load state entirely. LD_I exits after iram_cnt words, and LD_D exits after dram_cnt words.
REQ-013 The mode bits start, start_2, start_3 and start_4 are mutually exclusive, and at least one idle cycle with all four at 0 separates any two of them.
REQ-014 RUN: start=1 for exactly RUN_CYCLES clocks, counted by an internal counter wide enough for RUN_CYCLES. Then start=0 and the FSM moves to DMP_RD.
REQ-015 If final_end <= final_start, dumping is skipped and the FSM goes to FIN.
REQ-016 DMP_RD:
- start_4=1, addr_ext=current dump address (initially final_start), read_en_ext=1.
- dram_in is captured into out_data exactly RD_LAT cycles after read_en_ext rises.
- read_en_ext then drops, and the FSM moves to DMP_OUT.
REQ-017 DMP_OUT: out_valid=1, and out_data is held stable until out_ready.
- out_last=1 when the address equals final_end-1.
- On transfer: the address increments, and the FSM goes to DMP_RD, or to FIN after the last word.
- Back-pressure of any length is tolerated without data loss.
REQ-018 The dump covers addresses final_start through final_end-1 inclusive, giving final_end-final_start words.
REQ-019 FIN: done=1 for one cycle, all strobes and mode bits are 0, and the FSM returns to IDLE.
REQ-020 Write strobes and read_en_ext are never asserted in the same cycle, and a strobe is never asserted without its matching mode bit.
REQ-021 In_valid while in_ready=0 is ignored. Words arriving during RUN or the dump are neither consumed nor buffered.

Reset
REQ-022 When reset_n=0 at a rising edge, the FSM enters IDLE from any state, including mid-load, RUN or dump. It also sets:
- 0: all counters, addresses, data registers, strobes, read_en_ext, start, start_2, start_3, start_4, out_valid, out_last, busy, done.
- 1: in_ready.
REQ-023 The first word accepted after reset is always treated as header word 0.

Verification
REQ-024 Load: header {3,2,5,7}, instructions {11,22,33}, data {44,55}.
- Expect IRAM writes to addr 1,2,3 with 11,22,33, then DRAM writes to addr 1,2 with 44,55.
- Each strobe is 1 cycle wide with addr/data stable ±1 cycle.
REQ-025 RUN (RUN_CYCLES=50): start is high for exactly 50 cycles and is preceded and followed by a cycle with all mode bits 0.
REQ-026 Dump with final_start=5, final_end=7, dram_in driven as address+100, out_ready=1: expect out_data 105 then 106, with out_last on 106, then a single done pulse.
REQ-027 Back-pressure: out_ready held 0 for 10 cycles during the dump. out_valid and out_data stay stable, and no word is skipped or duplicated.
REQ-028 Empty cases: header {0,0,4,4}. No write strobes occur, RUN still executes, no out_valid occurs, and done pulses.
REQ-029 Reset during LD_D after 1 of 2 data words: all outputs return to reset values on the next edge. A following full sequence then loads correctly from address 1.
